// File: rtl/req_hs_receiver.sv
// Four-phase request/acknowledge receiver: deglitches a synchronized request level,
// presents each request once as a valid/ready event and returns a registered acknowledge.
module req_hs_receiver #(
  parameter int unsigned FILT_CYC = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             sync_req,
  input  logic             evt_rdy,
  output logic             evt_vld,
  output logic             ack_out,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             proto_err
);

  typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

  localparam logic [3:0] FILT_LAST = 4'(FILT_CYC - 1);

  logic       req_f;
  logic [3:0] filt_cnt;

  state_t             state, state_next;
  logic               vld_next, ack_next, err_next;
  logic [CNT_W-1:0]   cnt_next;

  // A new level is adopted only after it has been sampled FILT_CYC times in a row.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      req_f    <= 1'b0;
      filt_cnt <= '0;
    end else if (sync_req != req_f) begin
      if (filt_cnt == FILT_LAST) begin
        req_f    <= sync_req;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state     <= IDLE;
      evt_vld   <= 1'b0;
      ack_out   <= 1'b0;
      evt_cnt   <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_next;
      evt_vld   <= vld_next;
      ack_out   <= ack_next;
      evt_cnt   <= cnt_next;
      proto_err <= err_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    vld_next   = evt_vld;
    ack_next   = ack_out;
    cnt_next   = evt_cnt;
    err_next   = proto_err;
    unique case (state)
      IDLE: begin
        if (req_f) begin
          state_next = PEND;
          vld_next   = 1'b1;
        end
      end
      PEND: begin
        // A dropped request is flagged but the pending event is still delivered.
        if (!req_f) err_next = 1'b1;
        if (evt_vld && evt_rdy) begin
          state_next = ACK;
          vld_next   = 1'b0;
          ack_next   = 1'b1;
          cnt_next   = evt_cnt + CNT_W'(1);
        end
      end
      ACK: begin
        if (!req_f) begin
          state_next = IDLE;
          ack_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        vld_next   = 1'b0;
        ack_next   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_req_hs_receiver.sv
// Directed self-checking bench for req_hs_receiver: one instance with the default
// filter length and one with FILT_CYC=1 for the short-pulse case.
module tb_req_hs_receiver;

  logic       rclk = 1'b0;
  logic       arst_l;
  logic       sync_req, evt_rdy, evt_vld, ack_out, proto_err;
  logic [7:0] evt_cnt;
  logic       sync_req2, evt_rdy2, evt_vld2, ack_out2, proto_err2;
  logic [7:0] evt_cnt2;

  int total = 0;
  int bad   = 0;

  always #5 rclk = ~rclk;

  req_hs_receiver #(.FILT_CYC(2), .CNT_W(8)) dut (
    .rclk(rclk), .arst_l(arst_l), .sync_req(sync_req), .evt_rdy(evt_rdy),
    .evt_vld(evt_vld), .ack_out(ack_out), .evt_cnt(evt_cnt), .proto_err(proto_err)
  );

  req_hs_receiver #(.FILT_CYC(1), .CNT_W(8)) dut_f1 (
    .rclk(rclk), .arst_l(arst_l), .sync_req(sync_req2), .evt_rdy(evt_rdy2),
    .evt_vld(evt_vld2), .ack_out(ack_out2), .evt_cnt(evt_cnt2), .proto_err(proto_err2)
  );

  // Advance past one rising edge; outputs are read and inputs changed 1 time unit later.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic test_reset;
    arst_l = 1'b0; sync_req = 1'b0; evt_rdy = 1'b0; sync_req2 = 1'b0; evt_rdy2 = 1'b0;
    #3;
    total++; if ({evt_vld, ack_out, proto_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {evt_vld, ack_out, proto_err}); end
    total++; if (evt_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", evt_cnt); end
    total++; if ({evt_vld2, ack_out2, proto_err2} !== 3'b000) begin bad++; $display("FAIL reset_flags_f1 got=%b exp=000", {evt_vld2, ack_out2, proto_err2}); end
    step();
    arst_l = 1'b1;
    step(2);
    total++; if ({evt_vld, ack_out, evt_cnt} !== 10'd0) begin bad++; $display("FAIL reset_idle got=%b exp=0", {evt_vld, ack_out, evt_cnt}); end
  endtask

  task automatic test_basic;
    evt_rdy  = 1'b1;
    sync_req = 1'b1;
    step();  // E0
    total++; if (evt_vld !== 1'b0) begin bad++; $display("FAIL basic_vld_e0 got=%b exp=0", evt_vld); end
    step();  // E1
    total++; if (evt_vld !== 1'b0) begin bad++; $display("FAIL basic_vld_e1 got=%b exp=0", evt_vld); end
    step();  // E2
    total++; if ({evt_vld, ack_out} !== 2'b10) begin bad++; $display("FAIL basic_vld_e2 got=%b exp=10", {evt_vld, ack_out}); end
    step();  // E3
    total++; if ({evt_vld, ack_out} !== 2'b01) begin bad++; $display("FAIL basic_ack_e3 got=%b exp=01", {evt_vld, ack_out}); end
    total++; if (evt_cnt !== 8'd1) begin bad++; $display("FAIL basic_cnt got=%0d exp=1", evt_cnt); end
    step(2);
    total++; if (evt_vld !== 1'b0) begin bad++; $display("FAIL basic_no_refire got=%b exp=0", evt_vld); end
    sync_req = 1'b0;
    step(2); // R, R+1
    total++; if (ack_out !== 1'b1) begin bad++; $display("FAIL basic_ack_hold got=%b exp=1", ack_out); end
    step();  // R+2
    total++; if (ack_out !== 1'b0) begin bad++; $display("FAIL basic_ack_fall got=%b exp=0", ack_out); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", proto_err); end
  endtask

  task automatic test_glitch;
    evt_rdy2  = 1'b1;
    sync_req  = 1'b1;
    sync_req2 = 1'b1;
    step();  // E0
    sync_req  = 1'b0;
    sync_req2 = 1'b0;
    step();  // E1: FILT_CYC=1 instance goes pending
    total++; if (evt_vld2 !== 1'b1) begin bad++; $display("FAIL glitch_f1_vld got=%b exp=1", evt_vld2); end
    step(4);
    total++; if ({evt_vld, ack_out} !== 2'b00) begin bad++; $display("FAIL glitch_rejected got=%b exp=00", {evt_vld, ack_out}); end
    total++; if (evt_cnt !== 8'd1) begin bad++; $display("FAIL glitch_cnt got=%0d exp=1", evt_cnt); end
    total++; if (evt_cnt2 !== 8'd1) begin bad++; $display("FAIL glitch_f1_cnt got=%0d exp=1", evt_cnt2); end
    total++; if ({ack_out2, proto_err2} !== 2'b01) begin bad++; $display("FAIL glitch_f1_flags got=%b exp=01", {ack_out2, proto_err2}); end
  endtask

  task automatic test_backpressure;
    evt_rdy  = 1'b0;
    sync_req = 1'b1;
    step(3);
    total++; if (evt_vld !== 1'b1) begin bad++; $display("FAIL bp_vld_rise got=%b exp=1", evt_vld); end
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if ({evt_vld, ack_out} !== 2'b10) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b exp=10", i, {evt_vld, ack_out}); end
    end
    evt_rdy = 1'b1;
    step();
    total++; if ({evt_vld, ack_out} !== 2'b01) begin bad++; $display("FAIL bp_accept got=%b exp=01", {evt_vld, ack_out}); end
    total++; if (evt_cnt !== 8'd2) begin bad++; $display("FAIL bp_cnt got=%0d exp=2", evt_cnt); end
    sync_req = 1'b0;
    step(3);
    total++; if (ack_out !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", ack_out); end
  endtask

  task automatic test_proto_err;
    evt_rdy  = 1'b0;
    sync_req = 1'b1;
    step(3);
    total++; if (evt_vld !== 1'b1) begin bad++; $display("FAIL pe_pending got=%b exp=1", evt_vld); end
    sync_req = 1'b0;
    step(2); // R, R+1: req_f just fell
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL pe_early got=%b exp=0", proto_err); end
    step();  // R+2
    total++; if ({proto_err, evt_vld} !== 2'b11) begin bad++; $display("FAIL pe_set got=%b exp=11", {proto_err, evt_vld}); end
    step(3);
    total++; if ({proto_err, evt_vld, ack_out} !== 3'b110) begin bad++; $display("FAIL pe_still_pending got=%b exp=110", {proto_err, evt_vld, ack_out}); end
    evt_rdy = 1'b1;
    step();  // accepted -> ACK
    total++; if ({evt_vld, ack_out, evt_cnt} !== {2'b01, 8'd3}) begin bad++; $display("FAIL pe_accept got=%b exp=%b", {evt_vld, ack_out, evt_cnt}, {2'b01, 8'd3}); end
    step();  // ACK sees req_f low -> IDLE
    total++; if ({ack_out, proto_err} !== 2'b01) begin bad++; $display("FAIL pe_idle got=%b exp=01", {ack_out, proto_err}); end
  endtask

  task automatic test_reset_mid;
    evt_rdy  = 1'b1;
    sync_req = 1'b1;
    step(4);
    total++; if (ack_out !== 1'b1) begin bad++; $display("FAIL rm_in_ack got=%b exp=1", ack_out); end
    arst_l = 1'b0;
    #1;
    total++; if ({ack_out, proto_err, evt_cnt} !== 10'd0) begin bad++; $display("FAIL rm_async_clear got=%b exp=0", {ack_out, proto_err, evt_cnt}); end
    evt_rdy = 1'b0;
    step();
    arst_l = 1'b1;
    step(2); // E0, E1 after release
    total++; if (evt_vld !== 1'b0) begin bad++; $display("FAIL rm_filter got=%b exp=0", evt_vld); end
    step();  // E2
    total++; if (evt_vld !== 1'b1) begin bad++; $display("FAIL rm_vld got=%b exp=1", evt_vld); end
    evt_rdy = 1'b1;
    step();
    total++; if (evt_cnt !== 8'd1) begin bad++; $display("FAIL rm_cnt_restart got=%0d exp=1", evt_cnt); end
    sync_req = 1'b0;
    step(3);
  endtask

  task automatic test_wrap;
    arst_l = 1'b0;
    step();
    arst_l  = 1'b1;
    evt_rdy = 1'b1;
    step();
    for (int i = 0; i < 256; i++) begin
      sync_req = 1'b1;
      step(4);
      sync_req = 1'b0;
      step(3);
      if (i == 254) begin
        total++; if (evt_cnt !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d exp=255", evt_cnt); end
      end
    end
    total++; if (evt_cnt !== 8'd0) begin bad++; $display("FAIL wrap_0 got=%0d exp=0", evt_cnt); end
    total++; if ({evt_vld, ack_out, proto_err} !== 3'b000) begin bad++; $display("FAIL wrap_idle got=%b exp=000", {evt_vld, ack_out, proto_err}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_backpressure();
    test_proto_err();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
